// File: rtl/weight_ram_writer.sv
// rtl/weight_ram_writer.sv - byte-stream loader that packs bytes into words and fills a weight RAM
//
// Purpose:
//   Accepts a byte stream over a valid/ready handshake. Packs the bytes
//   little-endian into DATA_WIDTH words and writes them sequentially into an
//   internal 2**ADDR_WIDTH-deep RAM. A registered read port serves the neuron
//   datapath.
//
// Optional feature macro: WEIGHT_CHECKSUM_EN
//   defined   : checksum is a running modulo-256 sum of accepted bytes
//   undefined : checksum is tied to 0
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   start      in   one-cycle pulse, begins a load (from IDLE or DONE)
//   abort      in   one-cycle pulse, cancels a load in progress
//   s_data     in   input byte
//   s_valid    in   s_data valid
//   s_ready    out  writer accepts a byte (high only in LOAD)
//   rd_en      in   read request
//   rd_addr    in   read word address
//   rd_data    out  registered read data, 1-cycle latency, 0 when rd_en was low
//   done       out  high while the RAM holds a complete load
//   busy       out  high while loading
//   word_count out  words written in the current/last load
//   checksum   out  running byte sum (see macro above)

module weight_ram_writer #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [7:0]            s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  done,
  output logic                  busy,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic [7:0]            checksum
);

  localparam int BPW    = DATA_WIDTH / 8;
  localparam int DEPTH  = 1 << ADDR_WIDTH;
  // A one-byte word still needs a 1-bit index so the declarations stay legal.
  localparam int BIDX_W = (BPW > 1) ? $clog2(BPW) : 1;

  localparam logic [BIDX_W-1:0]     LAST_BYTE = BIDX_W'(BPW - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [BIDX_W-1:0]       byte_idx_q, byte_idx_d;
  logic [DATA_WIDTH-1:0]   hold_q, hold_d;
  logic [ADDR_WIDTH:0]     word_count_q, word_count_d;
  logic [DATA_WIDTH-1:0]   rd_data_q;

  logic                    accept;
  logic                    load_entry;
  logic                    wr_en;
  logic [DATA_WIDTH-1:0]   wr_word;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Next-state / datapath control
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    byte_idx_d   = byte_idx_q;
    hold_d       = hold_q;
    word_count_d = word_count_q;
    accept       = 1'b0;
    load_entry   = 1'b0;
    wr_en        = 1'b0;

    // The word to be written combines the held lower bytes with the byte
    // arriving on the completing edge, so no extra cycle is spent.
    wr_word                     = hold_q;
    wr_word[DATA_WIDTH-1 -: 8]  = s_data;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_LOAD;
          load_entry = 1'b1;
        end
      end

      ST_LOAD: begin
        // Abort takes priority over any handshake on the same edge, so a
        // word completing on that edge is dropped.
        if (abort) begin
          state_d    = ST_IDLE;
          byte_idx_d = '0;
          hold_d     = '0;
        end else if (s_valid) begin
          accept = 1'b1;
          if (byte_idx_q == LAST_BYTE) begin
            wr_en        = 1'b1;
            byte_idx_d   = '0;
            hold_d       = '0;
            word_count_d = word_count_q + 1'b1;
            if (wr_ptr_q == LAST_ADDR) begin
              // Pointer is held at the last address rather than wrapping.
              state_d = ST_DONE;
            end else begin
              wr_ptr_d = wr_ptr_q + 1'b1;
            end
          end else begin
            for (int k = 0; k < BPW; k++) begin
              if (byte_idx_q == BIDX_W'(k)) begin
                hold_d[8*k +: 8] = s_data;
              end
            end
            byte_idx_d = byte_idx_q + 1'b1;
          end
        end
      end

      ST_DONE: begin
        if (start) begin
          state_d    = ST_LOAD;
          load_entry = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (load_entry) begin
      wr_ptr_d     = '0;
      byte_idx_d   = '0;
      hold_d       = '0;
      word_count_d = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      byte_idx_q   <= '0;
      hold_q       <= '0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      byte_idx_q   <= byte_idx_d;
      hold_q       <= hold_d;
      word_count_q <= word_count_d;
    end
  end

  // RAM array: contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= wr_word;
    end
  end

  // Read port samples the array before this edge's write lands, giving
  // read-before-write behaviour on an address collision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end else begin
      rd_data_q <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional running checksum
  // ---------------------------------------------------------------------------
`ifdef WEIGHT_CHECKSUM_EN
  logic [7:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (load_entry) begin
      checksum_d = 8'd0;
    end else if (accept) begin
      checksum_d = checksum_q + s_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      checksum_q <= 8'd0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = 8'd0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign s_ready    = (state_q == ST_LOAD);
  assign busy       = (state_q == ST_LOAD);
  assign done       = (state_q == ST_DONE);
  assign word_count = word_count_q;
  assign rd_data    = rd_data_q;

endmodule

// File: tb/tb_weight_ram_writer.sv
// tb/tb_weight_ram_writer.sv - directed self-checking bench for weight_ram_writer

module tb_weight_ram_writer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic        rd_en;
  logic [1:0]  rd_addr;
  logic [15:0] rd_data;
  logic        done;
  logic        busy;
  logic [2:0]  word_count;
  logic [7:0]  checksum;

  int checks = 0;
  int errors = 0;

`ifdef WEIGHT_CHECKSUM_EN
  localparam logic [7:0] CK_FULL  = 8'h64;
  localparam logic [7:0] CK_ABORT = 8'h31;
`else
  localparam logic [7:0] CK_FULL  = 8'h00;
  localparam logic [7:0] CK_ABORT = 8'h00;
`endif

  weight_ram_writer #(.ADDR_WIDTH(2), .DATA_WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .done       (done),
    .busy       (busy),
    .word_count (word_count),
    .checksum   (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    s_valid = 1'b1;
    s_data  = b;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [1:0] a, input logic [15:0] exp);
    rd_en   = 1'b1;
    rd_addr = a;
    tick();
    rd_en   = 1'b0;
    check(tag, {16'h0, rd_data}, {16'h0, exp});
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    s_data = 8'h00; s_valid = 1'b0; rd_en = 1'b0; rd_addr = 2'd0;
    tick(); tick();

    // Reset state
    check("rst_s_ready", s_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_word_count", word_count, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_checksum", checksum, 0);
    rst = 1'b1;
    tick();

    // Test 1: full back-to-back load
    do_start();
    check("t1_busy_after_start", busy, 1);
    check("t1_s_ready_after_start", s_ready, 1);
    for (int i = 1; i <= 7; i++) send(8'(i * 8'h11));
    check("t1_wc_before_last", word_count, 3);
    check("t1_done_before_last", done, 0);
    send(8'h88);
    check("t1_done", done, 1);
    check("t1_word_count", word_count, 4);
    check("t1_s_ready_low", s_ready, 0);
    check("t1_busy_low", busy, 0);
    check("t1_checksum", checksum, CK_FULL);
    read_chk("t1_mem0", 2'd0, 16'h2211);
    read_chk("t1_mem1", 2'd1, 16'h4433);
    read_chk("t1_mem3", 2'd3, 16'h8877);

    // Test 4: read latency and rd_en=0 clearing
    read_chk("t4_mem2", 2'd2, 16'h6655);
    tick();
    check("t4_rd_data_cleared", rd_data, 0);

    // Bytes offered in DONE are not accepted
    send(8'hFF); send(8'hFE);
    check("done_ignore_wc", word_count, 4);
    check("done_ignore_done", done, 1);
    read_chk("done_ignore_mem0", 2'd0, 16'h2211);

    // Test 3: abort after three bytes
    do_start();
    check("t3_done_cleared", done, 0);
    check("t3_wc_cleared", word_count, 0);
    send(8'hAA); send(8'hBB); send(8'hCC);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t3_busy", busy, 0);
    check("t3_done", done, 0);
    check("t3_s_ready", s_ready, 0);
    check("t3_word_count", word_count, 1);
    check("t3_checksum", checksum, CK_ABORT);
    read_chk("t3_mem0", 2'd0, 16'hBBAA);
    read_chk("t3_mem1_untouched", 2'd1, 16'h4433);

    // Bytes offered in IDLE are not accepted
    send(8'h55); send(8'h66);
    check("idle_ignore_wc", word_count, 1);
    check("idle_ignore_busy", busy, 0);

    // Abort coinciding with the completing handshake drops the word
    do_start();
    send(8'h01);
    s_valid = 1'b1; s_data = 8'h02; abort = 1'b1;
    tick();
    s_valid = 1'b0; abort = 1'b0;
    check("abort_win_state", busy, 0);
    check("abort_win_wc", word_count, 0);
    read_chk("abort_win_mem0", 2'd0, 16'hBBAA);

    // Test 2: restart at address 0 with a 3-cycle gap between byte 1 and 2
    do_start();
    send(8'h11);
    tick(); tick(); tick();
    check("t2_gap_busy", busy, 1);
    check("t2_gap_wc", word_count, 0);
    for (int i = 2; i <= 7; i++) send(8'(i * 8'h11));
    check("t2_done_before_last", done, 0);
    send(8'h88);
    check("t2_done", done, 1);
    check("t2_word_count", word_count, 4);
    check("t2_s_ready_low", s_ready, 0);
    check("t2_checksum", checksum, CK_FULL);
    read_chk("t2_mem0", 2'd0, 16'h2211);
    read_chk("t2_mem1", 2'd1, 16'h4433);
    read_chk("t2_mem2", 2'd2, 16'h6655);
    read_chk("t2_mem3", 2'd3, 16'h8877);

    // Test 5: reset in the middle of a load
    do_start();
    for (int i = 1; i <= 5; i++) send(8'(i));
    check("t5_busy_pre", busy, 1);
    check("t5_wc_pre", word_count, 2);
    rd_en = 1'b1; rd_addr = 2'd1;
    tick();
    rd_en = 1'b0;
    check("t5_rd_pre", rd_data, 16'h0403);
    rst = 1'b0;
    #1;
    check("t5_s_ready", s_ready, 0);
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_word_count", word_count, 0);
    check("t5_rd_data", rd_data, 0);
    check("t5_checksum", checksum, 0);
    tick();
    rst = 1'b1;
    tick();
    do_start();
    for (int i = 0; i < 8; i++) send(8'(8'hA0 + i));
    check("t5_done_after", done, 1);
    check("t5_wc_after", word_count, 4);
    read_chk("t5_mem0", 2'd0, 16'hA1A0);
    read_chk("t5_mem3", 2'd3, 16'hA7A6);

    // Read-before-write on a collision: old contents returned
    do_start();
    rd_en = 1'b1; rd_addr = 2'd0;
    send(8'h12);
    s_valid = 1'b1; s_data = 8'h34;
    tick();
    s_valid = 1'b0; rd_en = 1'b0;
    check("rbw_old", rd_data, 16'hA1A0);
    read_chk("rbw_new", 2'd0, 16'h3412);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/weight_ram_writer.md
Name: weight_ram_writer

Overview:
Write-side counterpart of the weight memory that streams weights out to the neurons. It accepts a byte stream over a valid/ready handshake from the host/loader path and packs the bytes little-endian into DATA_WIDTH words. It writes the words sequentially into an internal 2**ADDR_WIDTH-deep RAM and signals completion. A registered read port lets the neuron datapath fetch the loaded weights.

Parameters:
ADDR_WIDTH, 2, word address width; depth = 2**ADDR_WIDTH words
DATA_WIDTH, 16, stored word width; must be a multiple of 8; BPW = DATA_WIDTH/8 bytes per word

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse, begins a load
abort  in  1  one-cycle pulse, cancels a load in progress
s_data  in  8  input byte
s_valid  in  1  s_data valid
s_ready  out  1  writer can accept a byte
rd_en  in  1  read request
rd_addr  in  ADDR_WIDTH  read word address
rd_data  out  DATA_WIDTH  read data, registered
done  out  1  high while the RAM holds a complete load
busy  out  1  high while in LOAD
word_count  out  ADDR_WIDTH+1  words written in the current/last load
checksum  out  8  running byte sum (see Optional Feature)

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low. While rst=0: state=IDLE; s_ready, done, busy, word_count, rd_data and checksum = 0; write pointer and byte index cleared. RAM contents are not reset.
- FSM states: IDLE, LOAD, DONE.
  - IDLE: s_ready=0. start -> LOAD.
  - LOAD: s_ready=1, busy=1. abort -> IDLE; partial word discarded; words already written stay in the RAM; done stays 0. start is ignored.
  - DONE: done=1, s_ready=0. start -> LOAD, which clears done.
- Entry into LOAD (registered on the start edge): wr_ptr=0, byte_idx=0, word_count=0, checksum=0, done=0.
- Handshake: a byte transfers on each rising edge with s_valid=1 and s_ready=1. Gaps in s_valid are allowed, and partial-word state is held across them. Bytes offered outside LOAD are not accepted.
- Packing: byte k of a word (k=0..BPW-1) occupies bits [8k+7:8k], so the first byte goes to the LSBs.
- Write: on the edge that accepts byte BPW-1, the assembled word (held bytes plus the current byte) is written to mem[wr_ptr] in the same cycle. On that edge wr_ptr increments, word_count increments, and byte_idx returns to 0.
- Completion: on the edge that writes word 2**ADDR_WIDTH-1, the FSM moves to DONE. s_ready is low from the next cycle. word_count = 2**ADDR_WIDTH. No extra byte is ever accepted, and wr_ptr does not wrap into a second pass.
- Simultaneous abort and final handshake: abort wins. The final word is not written and the FSM goes to IDLE.
- Read port: rd_en=1 at edge N gives rd_data = mem[rd_addr] after edge N, i.e. 1-cycle latency. rd_en=0 at an edge gives rd_data=0 after that edge.
  - Reads are legal in any state.
  - Reading the address being written on the same edge returns the old contents (read-before-write).
- Reset asserted mid-load: immediate return to IDLE with all outputs 0. The next load starts from word 0.

Optional Feature:
WEIGHT_CHECKSUM_EN
- Defined: checksum is an 8-bit register, cleared on entry to LOAD. On every accepted byte, checksum <= checksum + s_data, with wrap modulo 256. The value holds in DONE and IDLE until the next load.
- Not defined: checksum is tied to 0 and no accumulator logic is generated.

Test Plan:
1. Full load, ADDR_WIDTH=2, DATA_WIDTH=16: start, then bytes 0x11,0x22,...,0x88 back-to-back -> mem words 0x2211, 0x4433, 0x6655, 0x8877. done=1 and word_count=4 after the 8th handshake; s_ready=0 the following cycle.
2. Backpressure/gaps: same bytes with s_valid dropped for 3 cycles between byte 1 and byte 2 -> identical RAM contents and done timing relative to the last handshake. Bytes driven in DONE or IDLE are not accepted.
3. Abort: start, bytes 0xAA,0xBB,0xCC, then abort -> IDLE, done=0, word_count=1, mem[0]=0xBBAA. A new start plus 8 bytes restarts at address 0.
4. Read latency: after test 1, rd_en=1 with rd_addr=2 -> rd_data=0x6655 one cycle later. rd_en=0 -> rd_data=0 after the next edge.
5. Reset mid-load: rst=0 after 5 bytes -> s_ready, busy, done, word_count immediately 0. After release and a fresh 8-byte load, mem[0]=first new word.
6. WEIGHT_CHECKSUM_EN defined, stimulus of test 1 -> checksum=0x64, i.e. 0x264 mod 256. Macro undefined -> checksum stays 0.
